// File: rtl/alarm_pkg.sv
// rtl/alarm_pkg.sv - shared state encoding and BCD width for the alarm controller
package alarm_pkg;
  localparam int DIGIT_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZED = 2'd2
  } alarm_state_t;
endpackage

// File: rtl/button_pulse.sv
// rtl/button_pulse.sv - synchronise and debounce a raw button, one pulse per press
module button_pulse #(
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic clk_100MHz,
  input  logic reset,
  input  logic btn,
  output logic pulse
);
  localparam int CW = $clog2(DB_CYCLES + 1);

  logic          sync1, sync2, fired;
  logic [CW-1:0] stable_ctr;

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      fired      <= 1'b0;
      stable_ctr <= '0;
      pulse      <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      pulse <= 1'b0;
      // fired holds off further pulses until the button is released
      if (!sync2) begin
        stable_ctr <= '0;
        fired      <= 1'b0;
      end else if (!fired) begin
        if (stable_ctr == CW'(DB_CYCLES - 1)) begin
          pulse <= 1'b1;
          fired <= 1'b1;
        end else begin
          stable_ctr <= stable_ctr + CW'(1);
        end
      end
    end
  end
endmodule

// File: rtl/alarm_controller.sv
// rtl/alarm_controller.sv - alarm match detection, ringing/snooze FSM and pulsed buzzer
module alarm_controller
  import alarm_pkg::*;
#(
  parameter int BEEP_HALF_CYC  = 12_500_000,
  parameter int RING_TIMEOUT_S = 60,
  parameter int SNOOZE_S       = 300,
  parameter int MAX_SNOOZE     = 3,
  parameter int DB_CYCLES      = 1_000_000
) (
  input  logic               clk_100MHz,
  input  logic               reset,
  input  logic               tick_1Hz,
  input  logic [DIGIT_W-1:0] sec_1s,
  input  logic [DIGIT_W-1:0] sec_10s,
  input  logic [DIGIT_W-1:0] min_1s,
  input  logic [DIGIT_W-1:0] min_10s,
  input  logic [DIGIT_W-1:0] hr_1s,
  input  logic [DIGIT_W-1:0] hr_10s,
  input  logic [DIGIT_W-1:0] alarm_min_1s,
  input  logic [DIGIT_W-1:0] alarm_min_10s,
  input  logic [DIGIT_W-1:0] alarm_hr_1s,
  input  logic [DIGIT_W-1:0] alarm_hr_10s,
  input  logic               alarm_en,
  input  logic               set_alarm,
  input  logic               btn_stop,
  input  logic               btn_snooze,
  output logic               buzzer,
  output logic               alarm_active,
  output logic               snooze_active,
  output logic [1:0]         snooze_count
);
  localparam int RW = $clog2(RING_TIMEOUT_S + 1);
  localparam int SW = $clog2(SNOOZE_S + 1);
  localparam int BW = $clog2(BEEP_HALF_CYC + 1);

  alarm_state_t  state;
  logic          tick_s1, tick_s2, tick_s3;
  logic          sec_pulse, match, stop_pulse, snooze_pulse;
  logic          beep_phase;
  logic [BW-1:0] beep_ctr;
  logic [RW-1:0] ring_secs;
  logic [SW-1:0] snooze_secs;

  button_pulse #(.DB_CYCLES(DB_CYCLES)) u_stop (
    .clk_100MHz(clk_100MHz), .reset(reset), .btn(btn_stop), .pulse(stop_pulse)
  );
  button_pulse #(.DB_CYCLES(DB_CYCLES)) u_snooze (
    .clk_100MHz(clk_100MHz), .reset(reset), .btn(btn_snooze), .pulse(snooze_pulse)
  );

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      tick_s1 <= 1'b0;
      tick_s2 <= 1'b0;
      tick_s3 <= 1'b0;
    end else begin
      tick_s1 <= tick_1Hz;
      tick_s2 <= tick_s1;
      tick_s3 <= tick_s2;
    end
  end

  // Seconds must be :00 so the match lasts for exactly one sec_pulse
  assign sec_pulse = tick_s2 & ~tick_s3;
  assign match = (hr_10s == alarm_hr_10s) && (hr_1s == alarm_hr_1s) &&
                 (min_10s == alarm_min_10s) && (min_1s == alarm_min_1s) &&
                 (sec_10s == '0) && (sec_1s == '0);

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      buzzer        <= 1'b0;
      alarm_active  <= 1'b0;
      snooze_active <= 1'b0;
      snooze_count  <= 2'd0;
      beep_phase    <= 1'b0;
      beep_ctr      <= '0;
      ring_secs     <= '0;
      snooze_secs   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sec_pulse && match && alarm_en && !set_alarm) begin
            state        <= RINGING;
            ring_secs    <= '0;
            snooze_count <= 2'd0;
            beep_phase   <= 1'b1;
            beep_ctr     <= '0;
            buzzer       <= 1'b1;
            alarm_active <= 1'b1;
          end
        end
        RINGING: begin
          if (stop_pulse || !alarm_en) begin
            state        <= IDLE;
            buzzer       <= 1'b0;
            alarm_active <= 1'b0;
          end else if (snooze_pulse && (snooze_count < 2'(MAX_SNOOZE))) begin
            state         <= SNOOZED;
            snooze_secs   <= '0;
            snooze_count  <= snooze_count + 2'd1;
            buzzer        <= 1'b0;
            alarm_active  <= 1'b0;
            snooze_active <= 1'b1;
          end else begin
            if (beep_ctr == BW'(BEEP_HALF_CYC - 1)) begin
              beep_ctr   <= '0;
              beep_phase <= ~beep_phase;
              buzzer     <= ~beep_phase;
            end else begin
              beep_ctr <= beep_ctr + BW'(1);
              buzzer   <= beep_phase;
            end
            // Timeout overrides the beep update above
            if (sec_pulse) begin
              if (ring_secs == RW'(RING_TIMEOUT_S - 1)) begin
                state        <= IDLE;
                buzzer       <= 1'b0;
                alarm_active <= 1'b0;
              end else begin
                ring_secs <= ring_secs + RW'(1);
              end
            end
          end
        end
        SNOOZED: begin
          if (stop_pulse || !alarm_en) begin
            state         <= IDLE;
            snooze_active <= 1'b0;
          end else if (sec_pulse) begin
            if (snooze_secs == SW'(SNOOZE_S - 1)) begin
              state         <= RINGING;
              ring_secs     <= '0;
              beep_phase    <= 1'b1;
              beep_ctr      <= '0;
              buzzer        <= 1'b1;
              alarm_active  <= 1'b1;
              snooze_active <= 1'b0;
            end else begin
              snooze_secs <= snooze_secs + SW'(1);
            end
          end
        end
        default: begin
          state         <= IDLE;
          buzzer        <= 1'b0;
          alarm_active  <= 1'b0;
          snooze_active <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alarm_controller.sv
// tb/tb_alarm_controller.sv - directed self-checking bench for alarm_controller
module tb_alarm_controller;
  logic       clk_100MHz = 1'b0;
  logic       reset = 1'b1;
  logic       tick_1Hz = 1'b0;
  logic [3:0] sec_1s = 0, sec_10s = 0, min_1s = 0, min_10s = 0, hr_1s = 0, hr_10s = 0;
  logic [3:0] alarm_min_1s = 4'd0, alarm_min_10s = 4'd3, alarm_hr_1s = 4'd7, alarm_hr_10s = 4'd0;
  logic       alarm_en = 1'b1, set_alarm = 1'b0, btn_stop = 1'b0, btn_snooze = 1'b0;
  logic       buzzer, alarm_active, snooze_active;
  logic [1:0] snooze_count;
  int         errors = 0;
  int         checks = 0;

  alarm_controller #(
    .BEEP_HALF_CYC(4), .RING_TIMEOUT_S(5), .SNOOZE_S(3), .MAX_SNOOZE(2), .DB_CYCLES(4)
  ) dut (
    .clk_100MHz(clk_100MHz), .reset(reset), .tick_1Hz(tick_1Hz),
    .sec_1s(sec_1s), .sec_10s(sec_10s), .min_1s(min_1s), .min_10s(min_10s),
    .hr_1s(hr_1s), .hr_10s(hr_10s),
    .alarm_min_1s(alarm_min_1s), .alarm_min_10s(alarm_min_10s),
    .alarm_hr_1s(alarm_hr_1s), .alarm_hr_10s(alarm_hr_10s),
    .alarm_en(alarm_en), .set_alarm(set_alarm),
    .btn_stop(btn_stop), .btn_snooze(btn_snooze),
    .buzzer(buzzer), .alarm_active(alarm_active),
    .snooze_active(snooze_active), .snooze_count(snooze_count)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  task automatic set_time(input int h, input int m, input int s);
    hr_10s = 4'(h / 10); hr_1s = 4'(h % 10);
    min_10s = 4'(m / 10); min_1s = 4'(m % 10);
    sec_10s = 4'(s / 10); sec_1s = 4'(s % 10);
  endtask

  task automatic tick_full();
    tick_1Hz = 1'b1;
    repeat (20) @(negedge clk_100MHz);
    tick_1Hz = 1'b0;
    repeat (20) @(negedge clk_100MHz);
  endtask

  task automatic trigger();
    set_time(7, 29, 59);
    tick_full();
    set_time(7, 30, 0);
    tick_full();
    set_time(7, 30, 1);
  endtask

  task automatic press(input logic stop, input logic snooze);
    btn_stop = stop;
    btn_snooze = snooze;
    repeat (6) @(negedge clk_100MHz);
    btn_stop = 1'b0;
    btn_snooze = 1'b0;
    repeat (4) @(negedge clk_100MHz);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk_100MHz);
    checks++; if (buzzer !== 1'b0) begin errors++; $display("FAIL reset_buzzer got=%b exp=0", buzzer); end
    checks++; if (alarm_active !== 1'b0) begin errors++; $display("FAIL reset_alarm_active got=%b exp=0", alarm_active); end
    checks++; if (snooze_active !== 1'b0) begin errors++; $display("FAIL reset_snooze_active got=%b exp=0", snooze_active); end
    checks++; if (snooze_count !== 2'd0) begin errors++; $display("FAIL reset_snooze_count got=%0d exp=0", snooze_count); end
    reset = 1'b0;
    repeat (2) @(negedge clk_100MHz);
  endtask

  task automatic test_trigger();
    set_time(7, 29, 59);
    tick_full();
    checks++; if (alarm_active !== 1'b0) begin errors++; $display("FAIL pre_match_idle got=%b exp=0", alarm_active); end
    set_time(7, 30, 0);
    tick_1Hz = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk_100MHz);
      if (i == 2) begin
        checks++; if (alarm_active !== 1'b0) begin errors++; $display("FAIL ring_latency_early got=%b exp=0", alarm_active); end
      end
      if (i == 3) begin
        checks++; if (alarm_active !== 1'b1) begin errors++; $display("FAIL ring_latency got=%b exp=1", alarm_active); end
      end
      if (i >= 3 && i <= 18) begin
        checks++;
        if (buzzer !== ((((i - 3) / 4) % 2) == 0)) begin
          errors++; $display("FAIL beep_pattern cyc=%0d got=%b exp=%b", i - 3, buzzer, (((i - 3) / 4) % 2) == 0);
        end
      end
    end
    tick_1Hz = 1'b0;
    repeat (20) @(negedge clk_100MHz);
  endtask

  task automatic test_stop();
    press(1'b1, 1'b0);
    checks++; if (alarm_active !== 1'b0) begin errors++; $display("FAIL stop_idle got=%b exp=0", alarm_active); end
    checks++; if (buzzer !== 1'b0) begin errors++; $display("FAIL stop_buzzer got=%b exp=0", buzzer); end
    set_time(7, 30, 1);
    tick_full();
    checks++; if (alarm_active !== 1'b0) begin errors++; $display("FAIL no_retrigger got=%b exp=0", alarm_active); end
  endtask

  task automatic test_snooze();
    trigger();
    checks++; if (alarm_active !== 1'b1) begin errors++; $display("FAIL snooze_pre_ring got=%b exp=1", alarm_active); end
    for (int n = 1; n <= 2; n++) begin
      press(1'b0, 1'b1);
      checks++; if (snooze_active !== 1'b1) begin errors++; $display("FAIL snooze_enter n=%0d got=%b exp=1", n, snooze_active); end
      checks++; if (snooze_count !== 2'(n)) begin errors++; $display("FAIL snooze_count n=%0d got=%0d exp=%0d", n, snooze_count, n); end
      checks++; if (buzzer !== 1'b0) begin errors++; $display("FAIL snooze_buzzer n=%0d got=%b exp=0", n, buzzer); end
      tick_full();
      tick_full();
      checks++; if (snooze_active !== 1'b1) begin errors++; $display("FAIL snooze_hold n=%0d got=%b exp=1", n, snooze_active); end
      tick_full();
      checks++; if (alarm_active !== 1'b1 || snooze_active !== 1'b0) begin
        errors++; $display("FAIL snooze_return n=%0d got=%b%b exp=10", n, alarm_active, snooze_active);
      end
    end
    press(1'b0, 1'b1);
    checks++; if (alarm_active !== 1'b1 || snooze_active !== 1'b0) begin
      errors++; $display("FAIL snooze_limit got=%b%b exp=10", alarm_active, snooze_active);
    end
    checks++; if (snooze_count !== 2'd2) begin errors++; $display("FAIL snooze_limit_count got=%0d exp=2", snooze_count); end
  endtask

  task automatic test_stop_and_snooze();
    press(1'b1, 1'b0);
    trigger();
    checks++; if (snooze_count !== 2'd0) begin errors++; $display("FAIL count_clear_on_entry got=%0d exp=0", snooze_count); end
    press(1'b1, 1'b1);
    checks++; if (alarm_active !== 1'b0 || snooze_active !== 1'b0) begin
      errors++; $display("FAIL stop_priority got=%b%b exp=00", alarm_active, snooze_active);
    end
    checks++; if (snooze_count !== 2'd0) begin errors++; $display("FAIL stop_priority_count got=%0d exp=0", snooze_count); end
  endtask

  task automatic test_timeout();
    trigger();
    repeat (4) tick_full();
    checks++; if (alarm_active !== 1'b1) begin errors++; $display("FAIL timeout_early got=%b exp=1", alarm_active); end
    tick_1Hz = 1'b1;
    repeat (2) @(negedge clk_100MHz);
    checks++; if (alarm_active !== 1'b1) begin errors++; $display("FAIL timeout_edge_pre got=%b exp=1", alarm_active); end
    @(negedge clk_100MHz);
    checks++; if (alarm_active !== 1'b0) begin errors++; $display("FAIL timeout got=%b exp=0", alarm_active); end
    checks++; if (buzzer !== 1'b0) begin errors++; $display("FAIL timeout_buzzer got=%b exp=0", buzzer); end
    repeat (17) @(negedge clk_100MHz);
    tick_1Hz = 1'b0;
    repeat (20) @(negedge clk_100MHz);
  endtask

  task automatic test_suppress();
    set_alarm = 1'b1;
    trigger();
    checks++; if (alarm_active !== 1'b0) begin errors++; $display("FAIL set_alarm_suppress got=%b exp=0", alarm_active); end
    set_alarm = 1'b0;
    alarm_en = 1'b0;
    trigger();
    checks++; if (alarm_active !== 1'b0) begin errors++; $display("FAIL disarmed_suppress got=%b exp=0", alarm_active); end
    alarm_en = 1'b1;
    set_time(7, 29, 59);
    tick_full();
    set_time(7, 30, 5);
    tick_full();
    checks++; if (alarm_active !== 1'b0) begin errors++; $display("FAIL time_jump got=%b exp=0", alarm_active); end
  endtask

  task automatic test_disarm_and_reset();
    trigger();
    alarm_en = 1'b0;
    repeat (2) @(negedge clk_100MHz);
    checks++; if (alarm_active !== 1'b0) begin errors++; $display("FAIL disarm_mid_ring got=%b exp=0", alarm_active); end
    alarm_en = 1'b1;
    trigger();
    checks++; if (alarm_active !== 1'b1) begin errors++; $display("FAIL reset_pre_ring got=%b exp=1", alarm_active); end
    @(negedge clk_100MHz);
    #2 reset = 1'b1;
    #1;
    checks++; if ({buzzer, alarm_active, snooze_active, snooze_count} !== 5'b0) begin
      errors++; $display("FAIL async_reset got=%b%b%b%0d exp=0000", buzzer, alarm_active, snooze_active, snooze_count);
    end
    @(negedge clk_100MHz);
    reset = 1'b0;
    repeat (2) @(negedge clk_100MHz);
  endtask

  initial begin
    test_reset();
    test_trigger();
    test_stop();
    test_snooze();
    test_stop_and_snooze();
    test_timeout();
    test_suppress();
    test_disarm_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
